updi_prog_controller: RTL and testbench

- Parametrised UPDI programming sequencer; next generation of the fixed-function programmer state machine.
- Runs the full unlock/erase/program/verify flow for a ROM image of configurable size, page size and flash base.
- Issues single UPDI transactions to the UART/UPDI transaction layer over a valid/ready command and response handshake.
- Reads the image from a synchronous ROM port. Adds bounded retries, poll timeouts, optional verify, progress reporting and coded errors.

---
 rtl/updi_prog_controller.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_updi_prog_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_prog_controller.sv
// UPDI programming sequencer: unlock, chip erase, page-wise flash write and optional
// read-back verify of a ROM image, one transaction at a time over a valid/ready link.
module updi_prog_controller #(
    parameter int          ROM_BYTES   = 2048,
    parameter int          PAGE_BYTES  = 64,
    parameter logic [15:0] FLASH_BASE  = 16'h8000,
    parameter int          MAX_RETRIES = 3,
    parameter int          POLL_LIMIT  = 1024,
    parameter bit          VERIFY_EN   = 1'b1,
    parameter int          AW          = $clog2(ROM_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [3:0]    err_code,
    output logic [AW-1:0] progress,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [2:0]    cmd_op,
    output logic [15:0]   cmd_addr,
    output logic [7:0]    cmd_data,
    input  logic          rsp_valid,
    input  logic [7:0]    rsp_data,
    input  logic          rsp_err,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data
);

    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] OP_BRK  = 3'd0;
    localparam logic [2:0] OP_STCS = 3'd1;
    localparam logic [2:0] OP_LDCS = 3'd2;
    localparam logic [2:0] OP_KEY  = 3'd3;
    localparam logic [2:0] OP_STS8 = 3'd4;
    localparam logic [2:0] OP_LDS8 = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_BREAK, S_STAT, S_KEY_ER, S_RST_ON, S_RST_OFF, S_POLL_LOCK,
        S_KEY_NVM, S_POLL_PROG, S_PBC, S_WR, S_CMT, S_POLL_NVM, S_VERIFY
    } state_t;

    // Every command walks WAIT (ROM settle, rom_data users only) -> LOAD -> SEND -> RSP.
    typedef enum logic [1:0] {P_WAIT, P_LOAD, P_SEND, P_RSP} phase_t;

    state_t  state, state_n, ret_q, ret_n;
    phase_t  phase, phase_n;

    logic [RW-1:0] retry_cnt;
    logic [PW-1:0] poll_cnt;
    logic [7:0]    exp_q;
    logic          last_q, pg_end_q;

    logic          abort, finish, retry, poll_step, prog_inc, ver_start, go;
    logic [3:0]    abort_code;
    logic          accept, good, rom_cmd;
    logic [2:0]    ld_op;
    logic [15:0]   ld_addr;
    logic [7:0]    ld_data;

    assign busy      = (state != S_IDLE);
    assign cmd_valid = (phase == P_SEND) && (state != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign good      = (phase == P_RSP) && rsp_valid && !rsp_err;
    assign rom_cmd   = (state == S_WR) || (state == S_VERIFY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            phase <= P_LOAD;
            ret_q <= S_IDLE;
        end else begin
            state <= state_n;
            phase <= phase_n;
            ret_q <= ret_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        ret_n      = ret_q;
        abort      = 1'b0;
        abort_code = 4'd0;
        finish     = 1'b0;
        retry      = 1'b0;
        poll_step  = 1'b0;
        prog_inc   = 1'b0;
        ver_start  = 1'b0;
        go         = 1'b0;
        case (phase)
            P_WAIT: phase_n = P_LOAD;
            P_LOAD: if (state != S_IDLE) phase_n = P_SEND;
            P_SEND: if (cmd_ready) begin
                phase_n  = P_RSP;
                prog_inc = (state == S_WR);
            end
            P_RSP: if (rsp_valid) begin
                if (rsp_err) begin
                    if (retry_cnt == RW'(MAX_RETRIES)) begin
                        abort      = 1'b1;
                        abort_code = 4'd2;
                    end else begin
                        retry   = 1'b1;
                        phase_n = P_SEND;
                    end
                end else begin
                    phase_n = P_LOAD;
                    case (state)
                        S_BREAK:  state_n = S_STAT;
                        S_STAT: begin
                            if (rsp_data == 8'h00) begin
                                abort      = 1'b1;
                                abort_code = 4'd1;
                            end else begin
                                state_n = S_KEY_ER;
                            end
                        end
                        S_KEY_ER: begin
                            state_n = S_RST_ON;
                            ret_n   = S_POLL_LOCK;
                        end
                        S_RST_ON: state_n = S_RST_OFF;
                        S_RST_OFF: begin
                            state_n = ret_q;
                            finish  = (ret_q == S_IDLE);
                        end
                        S_POLL_LOCK: begin
                            if (!rsp_data[0]) state_n = S_KEY_NVM;
                            else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                                abort      = 1'b1;
                                abort_code = 4'd3;
                            end else poll_step = 1'b1;
                        end
                        S_KEY_NVM: begin
                            state_n = S_RST_ON;
                            ret_n   = S_POLL_PROG;
                        end
                        S_POLL_PROG: begin
                            if (rsp_data[3]) state_n = S_PBC;
                            else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                                abort      = 1'b1;
                                abort_code = 4'd4;
                            end else poll_step = 1'b1;
                        end
                        S_PBC:    state_n = S_WR;
                        S_WR:     if (pg_end_q) state_n = S_CMT;
                        S_CMT:    state_n = S_POLL_NVM;
                        S_POLL_NVM: begin
                            if (rsp_data[2]) begin
                                abort      = 1'b1;
                                abort_code = 4'd6;
                            end else if (!rsp_data[0]) begin
                                if (!last_q) state_n = S_PBC;
                                else if (VERIFY_EN) begin
                                    state_n   = S_VERIFY;
                                    ver_start = 1'b1;
                                end else begin
                                    state_n = S_RST_ON;
                                    ret_n   = S_IDLE;
                                end
                            end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                                abort      = 1'b1;
                                abort_code = 4'd5;
                            end else poll_step = 1'b1;
                        end
                        S_VERIFY: begin
                            if (rsp_data != exp_q) begin
                                abort      = 1'b1;
                                abort_code = 4'd7;
                            end else begin
                                prog_inc = 1'b1;
                                if (last_q) begin
                                    state_n = S_RST_ON;
                                    ret_n   = S_IDLE;
                                end
                            end
                        end
                        default: ;
                    endcase
                    if (state_n == S_WR || state_n == S_VERIFY) phase_n = P_WAIT;
                end
            end
            default: ;
        endcase
        if (state == S_IDLE && start) begin
            go      = 1'b1;
            state_n = S_BREAK;
            phase_n = P_LOAD;
        end
        if (abort) begin
            state_n = S_IDLE;
            phase_n = P_LOAD;
        end
    end

    always_comb begin
        ld_op   = OP_BRK;
        ld_addr = 16'h0000;
        ld_data = 8'h00;
        case (state)
            S_STAT:      ld_op = OP_LDCS;
            S_KEY_ER:    ld_op = OP_KEY;
            S_KEY_NVM: begin
                ld_op   = OP_KEY;
                ld_addr = 16'h0001;
            end
            S_RST_ON: begin
                ld_op   = OP_STCS;
                ld_addr = 16'h0008;
                ld_data = 8'h59;
            end
            S_RST_OFF: begin
                ld_op   = OP_STCS;
                ld_addr = 16'h0008;
            end
            S_POLL_LOCK, S_POLL_PROG: begin
                ld_op   = OP_LDCS;
                ld_addr = 16'h000B;
            end
            S_PBC: begin
                ld_op   = OP_STS8;
                ld_addr = 16'h1000;
                ld_data = 8'h04;
            end
            S_WR: begin
                ld_op   = OP_STS8;
                ld_addr = FLASH_BASE + 16'(rom_addr);
                ld_data = rom_data;
            end
            S_CMT: begin
                ld_op   = OP_STS8;
                ld_addr = 16'h1000;
                ld_data = 8'h01;
            end
            S_POLL_NVM: begin
                ld_op   = OP_LDS8;
                ld_addr = 16'h1002;
            end
            S_VERIFY: begin
                ld_op   = OP_LDS8;
                ld_addr = FLASH_BASE + 16'(rom_addr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 4'd0;
            progress  <= '0;
            rom_addr  <= '0;
            retry_cnt <= '0;
            poll_cnt  <= '0;
            exp_q     <= 8'h00;
            last_q    <= 1'b0;
            pg_end_q  <= 1'b0;
            cmd_op    <= OP_BRK;
            cmd_addr  <= 16'h0000;
            cmd_data  <= 8'h00;
        end else begin
            done  <= finish;
            error <= abort;
            if (go) begin
                err_code <= 4'd0;
                progress <= '0;
                rom_addr <= '0;
            end
            if (abort) err_code <= abort_code;
            if (ver_start) begin
                rom_addr <= '0;
                progress <= '0;
            end
            // rom_addr moves on at acceptance, so page/image end is judged on the old address.
            if (accept && rom_cmd) begin
                rom_addr <= rom_addr + 1'b1;
                last_q   <= (rom_addr == AW'(ROM_BYTES - 1));
                pg_end_q <= ((rom_addr & AW'(PAGE_BYTES - 1)) == AW'(PAGE_BYTES - 1));
            end
            if (prog_inc) progress <= progress + 1'b1;
            if (go || good)  retry_cnt <= '0;
            else if (retry)  retry_cnt <= retry_cnt + 1'b1;
            if (state_n != state) poll_cnt <= '0;
            else if (poll_step)   poll_cnt <= poll_cnt + 1'b1;
            if (phase == P_LOAD) begin
                cmd_op   <= ld_op;
                cmd_addr <= ld_addr;
                cmd_data <= ld_data;
                if (state == S_VERIFY) exp_q <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_updi_prog_controller.sv
// Bench for updi_prog_controller: behavioural UPDI target, flow-level command scoreboard.
module tb_updi_prog_controller;
    localparam int ROMB = 128;
    localparam int PAGE = 64;
    localparam int MAXR = 3;
    localparam int PLIM = 8;
    localparam int AW   = 7;

    typedef struct { logic [2:0] op; logic [15:0] addr; logic [7:0] data; } cmd_t;
    typedef struct { bit is_err; int code; int prog; } out_t;

    logic          clk, rst, start, busy, done, error, cmd_valid, cmd_ready;
    logic          rsp_valid, rsp_err;
    logic [3:0]    err_code;
    logic [AW-1:0] progress, rom_addr;
    logic [2:0]    cmd_op;
    logic [15:0]   cmd_addr;
    logic [7:0]    cmd_data, rsp_data, rom_data;

    updi_prog_controller #(.ROM_BYTES(ROMB), .PAGE_BYTES(PAGE), .FLASH_BASE(16'h8000),
        .MAX_RETRIES(MAXR), .POLL_LIMIT(PLIM), .VERIFY_EN(1'b1), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .progress(progress), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rom_addr(rom_addr), .rom_data(rom_data));

    int   checks = 0, errors = 0;
    cmd_t cmd_q[$];
    out_t out_q[$];
    logic [7:0] rom[ROMB];
    logic [7:0] flash[ROMB];
    int   cfg_stat_errs, cfg_fbusy, cfg_corrupt, cfg_stall;
    bit   cfg_lock_stuck, spurious_req, outcome_seen;
    int   stat_err_left, fbusy_left, wr_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Target-side behaviour: CS reads, NVM controller status and a flash array.
    task automatic target_exec(input logic [2:0] op, input logic [15:0] addr,
                               input logic [7:0] data, output logic [7:0] rd, output logic re);
        int idx;
        rd  = 8'h00;
        re  = 1'b0;
        idx = int'(addr) - 'h8000;
        case (op)
            3'd2: if (addr == 16'h0000) begin
                      rd = 8'h30;
                      if (stat_err_left > 0) begin re = 1'b1; stat_err_left--; end
                  end else if (addr == 16'h000B) rd = cfg_lock_stuck ? 8'h01 : 8'h08;
            3'd4: if (addr == 16'h1000) begin
                      if (data == 8'h01) fbusy_left = cfg_fbusy;
                  end else if (idx >= 0 && idx < ROMB) flash[idx] = (idx == cfg_corrupt) ? ~data : data;
            3'd5: if (addr == 16'h1002) begin
                      if (fbusy_left > 0) begin rd = 8'h01; fbusy_left--; end
                  end else if (idx >= 0 && idx < ROMB) rd = flash[idx];
            default: ;
        endcase
    endtask

    // Driver: ready back-pressure and delayed single-cycle responses.
    initial begin
        int wait_cnt = 0, lat = 0;
        bit pend = 0;
        logic [7:0] rd;
        logic re;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 8'h00;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
            cmd_ready = 1'b0;
            if (rst) begin
                pend = 0;
                wait_cnt = cfg_stall;
            end else begin
                if (pend) begin
                    if (lat == 0) begin
                        rsp_valid = 1'b1; rsp_data = rd; rsp_err = re; pend = 0;
                    end else lat--;
                end else if (spurious_req) begin
                    rsp_valid = 1'b1; rsp_data = 8'hA5; spurious_req = 0;
                end
                if (cmd_valid && !pend && !rsp_valid) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        cmd_ready = 1'b1;
                        target_exec(cmd_op, cmd_addr, cmd_data, rd, re);
                        pend = 1;
                        lat = $urandom_range(0, 2);
                        wait_cnt = (cfg_stall > 0) ? cfg_stall : $urandom_range(0, 2);
                    end
                end
            end
        end
    end

    // Monitor: pops expected commands on acceptance and expected outcome on done/error.
    initial begin
        bit   held = 0;
        cmd_t hc, e;
        out_t o;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("hold_valid", cmd_valid, 1);
                    chk("hold_op", cmd_op, hc.op);
                    chk("hold_addr", cmd_addr, hc.addr);
                    chk("hold_data", cmd_data, hc.data);
                end
                held = 0;
                if (cmd_valid && !cmd_ready) begin
                    held = 1; hc.op = cmd_op; hc.addr = cmd_addr; hc.data = cmd_data;
                end
                if (cmd_valid && cmd_ready) begin
                    if (cmd_q.size() == 0) chk("extra_cmd", cmd_op, 7);
                    else begin
                        e = cmd_q.pop_front();
                        chk("cmd_op", cmd_op, e.op);
                        if (e.op != 3'd0) chk("cmd_addr", cmd_addr, e.addr);
                        if (e.op == 3'd1 || e.op == 3'd4) chk("cmd_data", cmd_data, e.data);
                    end
                    if (cmd_op == 3'd4 && cmd_addr >= 16'h8000) begin
                        chk("wr_progress", progress, wr_seen % (1 << AW));
                        wr_seen++;
                    end
                end
                if (done || error) begin
                    if (out_q.size() == 0) chk("unexpected_end", {done, error}, 0);
                    else begin
                        o = out_q.pop_front();
                        chk("error_pulse", error, o.is_err);
                        chk("done_pulse", done, !o.is_err);
                        chk("err_code", err_code, o.code);
                        chk("end_progress", progress, o.prog);
                    end
                    outcome_seen = 1;
                end
            end
        end
    end

    task automatic push(input int op, input int addr, input int data);
        cmd_t c;
        c.op = 3'(op); c.addr = 16'(addr); c.data = 8'(data);
        cmd_q.push_back(c);
    endtask

    task automatic push_out(input bit is_err, input int code, input int prog);
        out_t o;
        o.is_err = is_err; o.code = code; o.prog = prog;
        out_q.push_back(o);
    endtask

    // Reference flow derived from the sequencing rules, not from the FSM.
    task automatic build_exp();
        int n;
        push(0, 0, 0);
        n = (cfg_stat_errs > MAXR) ? MAXR + 1 : cfg_stat_errs + 1;
        repeat (n) push(2, 0, 0);
        if (cfg_stat_errs > MAXR) begin push_out(1, 2, 0); return; end
        push(3, 0, 0); push(1, 8, 'h59); push(1, 8, 0);
        if (cfg_lock_stuck) begin
            repeat (PLIM) push(2, 'h0B, 0);
            push_out(1, 3, 0);
            return;
        end
        push(2, 'h0B, 0);
        push(3, 1, 0); push(1, 8, 'h59); push(1, 8, 0);
        push(2, 'h0B, 0);
        for (int p = 0; p < ROMB / PAGE; p++) begin
            push(4, 'h1000, 4);
            for (int b = 0; b < PAGE; b++) push(4, 'h8000 + p * PAGE + b, rom[p * PAGE + b]);
            push(4, 'h1000, 1);
            repeat (cfg_fbusy + 1) push(5, 'h1002, 0);
        end
        for (int i = 0; i < ROMB; i++) begin
            push(5, 'h8000 + i, 0);
            if (i == cfg_corrupt) begin push_out(1, 7, i); return; end
        end
        push(1, 8, 'h59); push(1, 8, 0);
        push_out(0, 0, ROMB % (1 << AW));
    endtask

    task automatic setup(input int serr, input bit lock, input int fb, input int cor, input int stall);
        cfg_stat_errs = serr; cfg_lock_stuck = lock; cfg_fbusy = fb;
        cfg_corrupt = cor; cfg_stall = stall;
        stat_err_left = serr; fbusy_left = 0; wr_seen = 0; outcome_seen = 0;
        for (int i = 0; i < ROMB; i++) begin
            rom[i] = 8'($urandom);
            flash[i] = 8'hFF;
        end
        cmd_q.delete(); out_q.delete();
        build_exp();
    endtask

    task automatic run(input int serr, input bit lock, input int fb, input int cor,
                       input int stall, input bit glitch);
        setup(serr, lock, fb, cor, stall);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20000 && !outcome_seen; i++) begin
            @(negedge clk);
            start = glitch && i >= 60 && i < 63;
        end
        start = 1'b0;
        chk("run_timeout", outcome_seen, 1);
        chk("cmds_left", cmd_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; spurious_req = 0;
        cfg_stall = 0; cfg_corrupt = -1; cfg_fbusy = 0; cfg_lock_stuck = 0; cfg_stat_errs = 0;
        for (int i = 0; i < ROMB; i++) rom[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);      chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_done", done, 0);      chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0); chk("rst_progress", progress, 0);
        chk("rst_rom_addr", rom_addr, 0);
        @(negedge clk); rst = 1'b0;
        spurious_req = 1;
        repeat (4) @(negedge clk);
        chk("spurious_busy", busy, 0);
        chk("spurious_cmd_valid", cmd_valid, 0);

        run(0, 0, 0, -1, 0, 0);
        run(0, 0, 0, -1, 5, 1);
        run(3, 0, 0, -1, 0, 0);
        run(4, 0, 0, -1, 0, 0);
        run(0, 1, 0, -1, 0, 0);
        run(0, 0, 3, -1, 0, 0);
        run(0, 0, 0, 'h25, 0, 0);
        run(0, 0, 1, $urandom_range(0, ROMB - 1), 0, 0);

        // Reset in the middle of the write of byte 10, then a clean rerun.
        setup(0, 0, 0, -1, 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 20000 && !hit; i++) begin
                @(negedge clk);
                hit = cmd_valid && cmd_op == 3'd4 && cmd_addr == 16'h800A;
            end
            chk("wr10_reached", hit, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);      chk("mid_rst_cmd_valid", cmd_valid, 0);
        chk("mid_rst_done", done, 0);      chk("mid_rst_error", error, 0);
        chk("mid_rst_err_code", err_code, 0); chk("mid_rst_progress", progress, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        run(0, 0, 0, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
